cmd_rx_decoder: RTL and testbench
=================================

# cmd_rx_decoder

Host-command receive path for the GPU core. It takes the byte stream from the UART receiver, frames and validates commands, and dispatches them. STATUS requests go to the status responder as a one-cycle `status_req` pulse. WRITE and CLEAR commands go to the core through a valid/ready handshake. Malformed frames are dropped and reported on a one-cycle error strobe.

## Interface
Parameters:
- `ADDR_W`, 16 — width of `cmd_addr`; legal range 1..16.
- `TIMEOUT_CYCLES`, 100000 — maximum idle gap between bytes of one frame before it is discarded; must be ≥ 2.

Ports:
- `CLK` in 1 — the single clock.
- `rst` in 1 — synchronous, active-high reset.
- `rx_data` in 8 — received byte; valid only while `rx_valid` = 1.
- `rx_valid` in 1 — one-cycle strobe per received byte; there is no backpressure.
- `status_req` out 1 — one-cycle pulse when a valid STATUS frame completes.
- `cmd_valid` out 1 — a WRITE or CLEAR command is pending; held until accepted.
- `cmd_op` out 2 — 2'd1 = WRITE, 2'd2 = CLEAR; 2'd0 when idle.
- `cmd_addr` out ADDR_W — WRITE address.
- `cmd_data` out 8 — WRITE data byte, or CLEAR colour.
- `cmd_ready` in 1 — core accepts the command on a cycle where `cmd_valid & cmd_ready`.
- `err_valid` out 1 — one-cycle error strobe.
- `err_code` out 3 — error cause: 1 bad opcode, 2 checksum, 3 timeout, 4 overrun. Held until the next error.

## Operation
- Frame format: opcode byte, then payload bytes, then a check byte. The check byte must equal the XOR of the opcode and every payload byte.
- Opcodes and payload lengths:
  - 0x01 STATUS: 0 payload bytes.
  - 0x02 WRITE: 3 payload bytes — addr_hi, addr_lo, data.
  - 0x03 CLEAR: 1 payload byte — colour.
- `cmd_addr` = {addr_hi, addr_lo}[ADDR_W-1:0]; upper bits are truncated.
- FSM states: S_IDLE, S_PAYLOAD, S_CHECK, S_ISSUE.
- S_IDLE:
  - On `rx_valid`, latch the opcode and seed the running XOR with it.
  - Opcode 0x01 → S_CHECK.
  - Opcode 0x02 or 0x03 → S_PAYLOAD, with the byte counter loaded to the payload length.
  - Any other opcode → error 1, stay in S_IDLE.
- S_PAYLOAD: each `rx_valid` byte is stored in its field, XORed into the running checksum, and the counter is decremented. When the last payload byte arrives → S_CHECK.
- S_CHECK: on `rx_valid`, compare the byte against the running XOR.
  - Mismatch → error 2, go to S_IDLE; nothing is dispatched.
  - Match, STATUS → pulse `status_req` next cycle, go to S_IDLE.
  - Match, WRITE/CLEAR → drive `cmd_valid`/`cmd_op`/`cmd_addr`/`cmd_data` next cycle, go to S_ISSUE.
- S_ISSUE: hold all `cmd_*` outputs stable until `cmd_valid & cmd_ready`. On the following cycle `cmd_valid` and `cmd_op` are 0, and the FSM is in S_IDLE.
- Overrun: any `rx_valid` seen while in S_ISSUE is dropped with error 4. This includes the cycle on which the handshake completes. The FSM does not change because of the dropped byte.
- Timeout:
  - A gap counter runs only in S_PAYLOAD and S_CHECK.
  - It clears on entry to those states and on every accepted byte, and increments on every cycle without `rx_valid`.
  - When it reaches TIMEOUT_CYCLES-1 without `rx_valid` → error 3, go to S_IDLE.
  - If `rx_valid` arrives on the cycle the count would expire, the byte wins and no timeout is raised.
- Only one error is raised per cycle. The error overrides any dispatch from the same frame.
- Reset:
  - All outputs go to 0: `status_req`, `cmd_valid`, `cmd_op`, `cmd_addr`, `cmd_data`, `err_valid`, `err_code`.
  - The FSM goes to S_IDLE; the counters and the XOR clear.
  - A reset in mid-frame or in S_ISSUE discards the command without any error.

## Timing
- Byte k is sampled on the rising edge where `rx_valid` = 1. No minimum spacing between bytes is required; back-to-back strobes are legal.
- Latency from check-byte strobe at edge N:
  - `status_req` = 1 during cycle N+1 only.
  - or `cmd_valid` = 1 from cycle N+1.
- `err_valid` asserts in the cycle after the offending byte or the expiring cycle, lasting one cycle.
- `cmd_*` outputs are registered; no combinational path exists from `rx_*` or `cmd_ready` to any output.
- A new opcode is accepted on the first `rx_valid` after returning to S_IDLE, including the cycle right after `status_req`.

## Test plan
- Bytes 0x01, 0x01 back-to-back → `status_req` pulses exactly one cycle, 1 cycle after the 2nd byte; no error.
- WRITE 0x02, 0x12, 0x34, 0xAB, check 0x02^0x12^0x34^0xAB = 0x8F, with `cmd_ready` = 0 for 5 cycles then 1 → `cmd_valid` held with op = 1, addr = 0x1234, data = 0xAB; the handshake completes once; bytes arriving during the hold give `err_code` = 4.
- CLEAR 0x03, 0x5A, bad check 0x00 → `err_valid` pulse with `err_code` = 2; no `cmd_valid`. A following valid 0x01, 0x01 still produces `status_req`.
- Opcode 0x7F → `err_code` = 1 next cycle; the FSM stays idle.
- TIMEOUT_CYCLES = 8: send 0x02 then silence → `err_code` = 3 seven cycles after the opcode. Repeat with the next byte arriving on the 7th cycle → no error and the frame continues.
- `rst` asserted after 0x02, 0x12 → all outputs 0. A subsequent full CLEAR 0x03, 0x07, 0x04 dispatches op = 2, data = 0x07.

Source files
------------

// File: rtl/cmd_rx_decoder.sv
// Host-command receive path: frames UART bytes into STATUS/WRITE/CLEAR commands,
// validates the XOR check byte and dispatches, flagging malformed frames on err_valid.
module cmd_rx_decoder #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              status_req,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_data,
  input  logic              cmd_ready,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam int                GAP_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 2);

  localparam logic [7:0] OP_STATUS = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;

  localparam logic [2:0] ERR_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_ISSUE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          lo_q, lo_d;
  logic [7:0]          dat_q, dat_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                status_req_q, status_req_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [1:0]          cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [7:0]          cmd_data_q, cmd_data_d;
  logic                err_valid_q, err_valid_d;
  logic [2:0]          err_code_q, err_code_d;

  logic [15:0] addr_full;
  logic        gap_expire;
  logic        check_ok;
  logic        handshake;

  assign addr_full  = {hi_q, lo_q};
  // Expiry is judged on the cycle the count would reach TIMEOUT_CYCLES-1; a byte that cycle wins.
  assign gap_expire = !rx_valid && (gap_q == GAP_LAST);
  assign check_ok   = (rx_data == xor_q);
  assign handshake  = cmd_valid_q && cmd_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      xor_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      dat_q        <= '0;
      gap_q        <= '0;
      status_req_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= '0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dat_q        <= dat_d;
      gap_q        <= gap_d;
      status_req_q <= status_req_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_STATUS)                            state_d = S_CHECK;
          else if (rx_data == OP_WRITE || rx_data == OP_CLEAR) state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          if (cnt_q == 2'd1) state_d = S_CHECK;
        end else if (gap_expire) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          state_d = (check_ok && op_q != OP_STATUS) ? S_ISSUE : S_IDLE;
        end else if (gap_expire) begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (handshake) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d         = op_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dat_d        = dat_q;
    gap_d        = gap_q;
    status_req_d = 1'b0;
    cmd_valid_d  = cmd_valid_q;
    cmd_op_d     = cmd_op_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          op_d  = rx_data;
          xor_d = rx_data;
          gap_d = '0;
          if (rx_data == OP_WRITE) begin
            cnt_d = 2'd3;
          end else if (rx_data == OP_CLEAR) begin
            cnt_d = 2'd1;
          end else if (rx_data != OP_STATUS) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OPCODE;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          xor_d = xor_q ^ rx_data;
          cnt_d = cnt_q - 2'd1;
          gap_d = '0;
          // The counter doubles as the field selector: WRITE counts 3..1, CLEAR only 1.
          if (cnt_q == 2'd3)      hi_d  = rx_data;
          else if (cnt_q == 2'd2) lo_d  = rx_data;
          else                    dat_d = rx_data;
        end else if (gap_expire) begin
          gap_d       = '0;
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          gap_d = '0;
          if (!check_ok) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
          end else if (op_q == OP_STATUS) begin
            status_req_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = (op_q == OP_WRITE) ? 2'd1 : 2'd2;
            cmd_addr_d  = (op_q == OP_WRITE) ? addr_full[ADDR_W-1:0] : '0;
            cmd_data_d  = dat_q;
          end
        end else if (gap_expire) begin
          gap_d       = '0;
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (rx_valid) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (handshake) begin
          cmd_valid_d = 1'b0;
          cmd_op_d    = 2'd0;
        end
      end
      default: ;
    endcase
  end

  assign status_req = status_req_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_data   = cmd_data_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_cmd_rx_decoder.sv
// Scoreboard bench for cmd_rx_decoder: stimulus pushes expected events with their
// cycle stamps; a negedge monitor pops and compares whenever the DUT presents output.
module tb_cmd_rx_decoder;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        status_req;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        err_valid;
  logic [2:0]  err_code;

  cmd_rx_decoder #(.ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .status_req (status_req),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } err_exp_t;

  int       status_exp_q[$];
  cmd_exp_t cmd_exp_q[$];
  err_exp_t err_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output asserted at cycle %0d with nothing expected", name, cyc);
  endtask

  // Byte is sampled on the next rising edge; e returns that edge's index.
  task automatic send(input logic [7:0] b, output int e);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    e        = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_status_req"}, status_req, 0);
    check({tag, "_cmd_valid"},  cmd_valid,  0);
    check({tag, "_cmd_op"},     cmd_op,     0);
    check({tag, "_cmd_addr"},   cmd_addr,   0);
    check({tag, "_cmd_data"},   cmd_data,   0);
    check({tag, "_err_valid"},  err_valid,  0);
    check({tag, "_err_code"},   err_code,   0);
  endtask

  task automatic expect_err(input int c, input logic [2:0] code);
    err_exp_t x;
    x.cyc  = c;
    x.code = code;
    err_exp_q.push_back(x);
  endtask

  task automatic expect_cmd(input int c, input logic [1:0] op, input logic [15:0] addr,
                            input logic [7:0] data);
    cmd_exp_t x;
    x.cyc  = c;
    x.op   = op;
    x.addr = addr;
    x.data = data;
    cmd_exp_q.push_back(x);
  endtask

  logic prev_cv;
  logic post_hs;

  always @(negedge CLK) begin : monitor
    int       sc;
    err_exp_t ex;
    cmd_exp_t cx;
    if (rst) begin
      prev_cv <= 1'b0;
      post_hs <= 1'b0;
    end else begin
      if (post_hs) begin
        check("cmd_valid_after_hs", cmd_valid, 0);
        check("cmd_op_after_hs",    cmd_op,    0);
      end
      post_hs <= 1'b0;

      if (status_req) begin
        if (status_exp_q.size() == 0) unexpected("status_req");
        else begin
          sc = status_exp_q.pop_front();
          check("status_req_cycle", cyc, sc);
        end
      end

      if (err_valid) begin
        if (err_exp_q.size() == 0) unexpected("err_valid");
        else begin
          ex = err_exp_q.pop_front();
          check("err_cycle", cyc, ex.cyc);
          check("err_code",  err_code, ex.code);
        end
      end

      if (cmd_valid) begin
        if (cmd_exp_q.size() == 0) unexpected("cmd_valid");
        else begin
          cx = cmd_exp_q[0];
          if (!prev_cv) check("cmd_valid_rise_cycle", cyc, cx.cyc);
          check("cmd_op", cmd_op, cx.op);
          if (cx.op == 2'd1) check("cmd_addr", cmd_addr, cx.addr);
          check("cmd_data", cmd_data, cx.data);
          if (cmd_ready) begin
            void'(cmd_exp_q.pop_front());
            post_hs <= 1'b1;
          end
        end
      end
      prev_cv <= cmd_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    int e_op;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset");
    @(posedge CLK);
    #1;
    rst = 1'b0;
    idle(1);

    // STATUS back-to-back
    send(8'h01, e);
    send(8'h01, e);
    status_exp_q.push_back(e);
    idle(3);

    // WRITE held for several cycles with overrun bytes, the last on the handshake cycle
    send(8'h02, e); send(8'h12, e); send(8'h34, e); send(8'hAB, e);
    send(8'h8F, e);
    expect_cmd(e, 2'd1, 16'h1234, 8'hAB);
    send(8'h55, e);
    expect_err(e, 3'd4);
    idle(1);
    send(8'h66, e);
    expect_err(e, 3'd4);
    idle(2);
    cmd_ready = 1'b1;
    send(8'h77, e);
    expect_err(e, 3'd4);
    cmd_ready = 1'b0;
    idle(3);

    // CLEAR with bad check byte, then a valid STATUS
    send(8'h03, e); send(8'h5A, e);
    send(8'h00, e);
    expect_err(e, 3'd2);
    idle(2);
    send(8'h01, e);
    send(8'h01, e);
    status_exp_q.push_back(e);
    idle(2);

    // Illegal opcode, followed immediately by STATUS
    send(8'h7F, e);
    expect_err(e, 3'd1);
    send(8'h01, e);
    send(8'h01, e);
    status_exp_q.push_back(e);
    idle(2);
    check("err_code_held", err_code, 1);

    // Timeout after the opcode alone
    send(8'h02, e);
    expect_err(e + 7, 3'd3);
    idle(10);

    // Each byte lands on the 7th cycle of silence: the frame survives
    cmd_ready = 1'b1;
    send(8'h02, e_op);
    idle(6);
    send(8'h12, e);
    send(8'h34, e);
    idle(6);
    send(8'hAB, e);
    idle(6);
    send(8'h8F, e);
    expect_cmd(e, 2'd1, 16'h1234, 8'hAB);
    idle(3);
    cmd_ready = 1'b0;
    check("err_code_after_timeout", err_code, 3);

    // Reset mid-frame, then a full CLEAR
    send(8'h02, e);
    send(8'h12, e);
    rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("midframe_reset");
    @(posedge CLK);
    #1;
    rst       = 1'b0;
    cmd_ready = 1'b1;
    send(8'h03, e); send(8'h07, e);
    send(8'h04, e);
    expect_cmd(e, 2'd2, 16'h0000, 8'h07);
    idle(4);
    cmd_ready = 1'b0;

    check("status_pending", status_exp_q.size(), 0);
    check("cmd_pending",    cmd_exp_q.size(),    0);
    check("err_pending",    err_exp_q.size(),    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
